uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmit path (TX FIFO write port, then the transmitter) between N_REQ byte-stream requesters. Grants are round-robin and frame-atomic: once a requester is granted, it owns the FIFO write port until it sends a byte flagged last. An optional source-tag header byte is written ahead of each frame. The block sits directly upstream of the transmitter top, driving its tx_wr_en/tx_wr_data and obeying its tx_full.

Parameters:
N_BIT, 8, data byte width
N_REQ, 4, number of requesters (2..16)
HDR_EN, 1, 1 = write header byte {4'hA, idx[3:0]} before each frame; 0 = no header
IDX_W, 4, index width; fixed at 4 so that N_REQ is at most 16

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester byte valid
req_data  in  N_REQ*N_BIT  per-requester byte; requester i occupies bits [i*N_BIT +: N_BIT]
req_last  in  N_REQ  per-requester end-of-frame flag, qualified by req_valid
req_ready  out  N_REQ  per-requester accept; a byte transfers when valid&&ready
tx_full  in  1  TX FIFO full flag
tx_wr_en  out  1  TX FIFO write strobe
tx_wr_data  out  N_BIT  TX FIFO write data
grant  out  N_REQ  one-hot current owner; all zero when idle
busy  out  1  high in HDR or DATA state

Behaviour:
- Reset (async, rst=1): state=IDLE, grant=0, rr_ptr=N_REQ-1 (requester 0 has first priority). Outputs are 0 while in reset: req_ready=0, tx_wr_en=0, tx_wr_data=0, busy=0.
- State machine: IDLE, HDR, DATA. State, grant and rr_ptr are registered. req_ready, tx_wr_en and tx_wr_data are combinational from the registered state/grant and the current inputs.
- IDLE:
  - If any req_valid is high, select the first valid index searching upward from rr_ptr+1, wrapping modulo N_REQ.
  - Register grant (one-hot) and idx.
  - Next state is HDR if HDR_EN=1, else DATA.
  - No write occurs in IDLE. Arbitration costs exactly 1 cycle.
- HDR:
  - tx_wr_en = ~tx_full; tx_wr_data = {4'hA, idx}, zero-extended or truncated to N_BIT.
  - On a write, go to DATA. While tx_full=1, hold with no write.
  - req_ready = 0 for all requesters.
- DATA:
  - req_ready[g] = ~tx_full for the granted g; all other ready bits are 0.
  - tx_wr_en = req_valid[g] && ~tx_full; tx_wr_data = req_data[g]. Data passes through with zero latency.
  - Transfer with req_last[g]=1: next state IDLE, rr_ptr<=g, grant cleared.
  - req_valid[g]=0 mid-frame: hold the grant and wait indefinitely. Other requesters are ignored.
- Requests from non-granted requesters are never accepted, and their valid/data are not required to stay stable.
- Single-byte frame (last on the first byte): HDR (if enabled) then one DATA byte, then IDLE.
- Back-to-back frames: minimum of 1 IDLE cycle between the last byte of one frame and the next header/data byte.
- tx_full asserted in the same cycle as valid: no write and no ready. The byte is taken on the first cycle with tx_full=0.
- Reset mid-frame: return to IDLE immediately. Bytes already in the FIFO are not retracted, and the requester must resend.
- Only the granted requester's req_last has any effect.
- tx_wr_en is never asserted while tx_full=1. At most one write per cycle.

Test Plan:
- HDR_EN=1, only req 0 sends 0x11,0x22,0x33 (last on 0x33) -> FIFO writes 0xA0,0x11,0x22,0x33 on consecutive cycles after a 1-cycle IDLE; grant=0001 throughout, then 0000.
- All 4 requesters continuously send 1-byte frames -> header sequence 0xA0,0xA1,0xA2,0xA3,0xA0; exactly 1 IDLE cycle between frames.
- req 2 granted, tx_full=1 for 5 cycles mid-frame -> no tx_wr_en and req_ready[2]=0 during the stall; the pending byte is written on the first cycle after tx_full falls, with no loss or duplication.
- req 1 drops valid for 3 cycles mid-frame while req 3 is valid -> grant stays 0010, req_ready[3]=0, and req 1's frame completes before req 3 is served.
- HDR_EN=0, req 3 sends 0x5A with last -> a single write of 0x5A; the next arbitration starts searching from req 0.
- rst pulsed while in DATA with req 1 granted -> all outputs 0 immediately; after release, req 0 wins a simultaneous request by req 0 and req 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-atomic arbiter sharing one UART TX FIFO write port
// between N_REQ byte-stream requesters. An optional source-tag header
// byte {4'hA, idx} is written ahead of each granted frame.
module uart_tx_arbiter #(
    parameter int N_BIT  = 8,
    parameter int N_REQ  = 4,
    parameter int HDR_EN = 1,
    parameter int IDX_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*N_BIT-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   tx_full,
    output logic                   tx_wr_en,
    output logic [N_BIT-1:0]       tx_wr_data,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // Arbitration result for the IDLE cycle
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [N_REQ-1:0] sel_grant;

    // Granted requester's inputs, muxed by the registered index
    logic             own_valid;
    logic             own_last;
    logic [N_BIT-1:0] own_data;

    // Header byte, fitted to N_BIT (zero-extended or truncated)
    logic [7:0]       hdr8;
    logic [N_BIT-1:0] hdr_byte;

    assign hdr8 = {4'hA, idx_q};

    // Fit the 8-bit header into the data width
    always_comb begin
        hdr_byte = '0;
        for (int b = 0; b < N_BIT && b < 8; b++) begin
            hdr_byte[b] = hdr8[b];
        end
    end

    // Search upward from rr_ptr+1 (wrapping) for the first valid requester
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_grant = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!sel_found && req_valid[i] &&
                    (i == (int'(rr_ptr_q) + k) % N_REQ)) begin
                    sel_found    = 1'b1;
                    sel_idx      = IDX_W'(i);
                    sel_grant[i] = 1'b1;
                end
            end
        end
    end

    // Select the currently granted requester's valid/last/data
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i == int'(idx_q)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*N_BIT +: N_BIT];
            end
        end
    end

    // Next-state and combinational outputs; a frame releases the port only on its last byte
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        rr_ptr_d   = rr_ptr_q;
        req_ready  = '0;
        tx_wr_en   = 1'b0;
        tx_wr_data = '0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = sel_grant;
                    idx_d   = sel_idx;
                    state_d = (HDR_EN != 0) ? HDR : DATA;
                end
            end
            HDR: begin
                tx_wr_en   = !tx_full;
                tx_wr_data = hdr_byte;
                if (!tx_full) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                req_ready  = grant_q & {N_REQ{!tx_full}};
                tx_wr_en   = own_valid && !tx_full;
                tx_wr_data = own_data;
                if (own_valid && !tx_full && own_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = idx_q;
                    grant_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant, owner index and round-robin pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            rr_ptr_q <= IDX_W'(N_REQ - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a
// randomized run checked against a frame-level reference model.
module tb_uart_tx_arbiter;

    localparam int N_BIT = 8;
    localparam int N_REQ = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*N_BIT-1:0] req_data;
    logic [N_REQ-1:0]       req_last;
    logic                   tx_full;

    logic [N_REQ-1:0]       req_ready,  req_ready0;
    logic                   tx_wr_en,   tx_wr_en0;
    logic [N_BIT-1:0]       tx_wr_data, tx_wr_data0;
    logic [N_REQ-1:0]       grant,      grant0;
    logic                   busy,       busy0;

    int checks = 0;
    int errors = 0;

    logic [8:0] rq [N_REQ][$];

    uart_tx_arbiter #(.N_BIT(N_BIT), .N_REQ(N_REQ), .HDR_EN(1), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_full(tx_full),
        .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .grant(grant), .busy(busy)
    );

    uart_tx_arbiter #(.N_BIT(N_BIT), .N_REQ(N_REQ), .HDR_EN(0), .IDX_W(4)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready0), .tx_full(tx_full),
        .tx_wr_en(tx_wr_en0), .tx_wr_data(tx_wr_data0), .grant(grant0), .busy(busy0)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete in time");
        $fatal(1);
    end

    function automatic logic [17:0] pack(input logic [3:0] rd, input logic en,
                                         input logic [7:0] wd, input logic [3:0] gr,
                                         input logic by);
        return {rd, en, wd, gr, by};
    endfunction

    function automatic logic [17:0] snap();
        return {req_ready, tx_wr_en, tx_wr_data, grant, busy};
    endfunction

    function automatic logic [17:0] snap0();
        return {req_ready0, tx_wr_en0, tx_wr_data0, grant0, busy0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_full   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] e;
        rst       = 1'b1;
        req_valid = '1;
        req_last  = '1;
        req_data  = '1;
        tx_full   = 1'b0;
        @(negedge clk);
        e = pack(4'h0, 1'b0, 8'h00, 4'h0, 1'b0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL reset_outputs: got %h expected %h", snap(), e); end
        checks++;
        if (snap0() !== e) begin errors++; $display("FAIL reset_outputs_nohdr: got %h expected %h", snap0(), e); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL reset_first_idle: got %h expected %h", snap(), e); end
        tick();
        @(negedge clk);
        e = pack(4'h0, 1'b1, 8'hA0, 4'h1, 1'b1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL reset_first_hdr: got %h expected %h", snap(), e); end
        e = pack(4'h1, 1'b1, 8'hFF, 4'h1, 1'b1);
        checks++;
        if (snap0() !== e) begin errors++; $display("FAIL reset_first_data_nohdr: got %h expected %h", snap0(), e); end
        tick();
    endtask

    task automatic test_single_frame();
        logic [17:0] e;
        logic [7:0]  bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        do_reset();
        req_valid = 4'b0001;
        req_data[7:0] = 8'h11;
        @(negedge clk);
        e = pack(4'h0, 1'b0, 8'h00, 4'h0, 1'b0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL single_idle: got %h expected %h", snap(), e); end
        tick();
        @(negedge clk);
        e = pack(4'h0, 1'b1, 8'hA0, 4'h1, 1'b1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL single_hdr: got %h expected %h", snap(), e); end
        tick();
        for (int k = 0; k < 3; k++) begin
            req_data[7:0] = bytes[k];
            req_last[0]   = (k == 2);
            @(negedge clk);
            e = pack(4'h1, 1'b1, bytes[k], 4'h1, 1'b1);
            checks++;
            if (snap() !== e) begin errors++; $display("FAIL single_data%0d: got %h expected %h", k, snap(), e); end
            tick();
        end
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        e = pack(4'h0, 1'b0, 8'h00, 4'h0, 1'b0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL single_release: got %h expected %h", snap(), e); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [17:0] e;
        int i;
        do_reset();
        req_valid = 4'hF;
        req_last  = 4'hF;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int f = 0; f < 5; f++) begin
            i = f % N_REQ;
            @(negedge clk);
            e = pack(4'h0, 1'b0, 8'h00, 4'h0, 1'b0);
            checks++;
            if (snap() !== e) begin errors++; $display("FAIL rr_idle%0d: got %h expected %h", f, snap(), e); end
            tick();
            @(negedge clk);
            e = pack(4'h0, 1'b1, 8'(8'hA0 + i), 4'(1 << i), 1'b1);
            checks++;
            if (snap() !== e) begin errors++; $display("FAIL rr_hdr%0d: got %h expected %h", f, snap(), e); end
            tick();
            @(negedge clk);
            e = pack(4'(1 << i), 1'b1, 8'(8'h10 + i), 4'(1 << i), 1'b1);
            checks++;
            if (snap() !== e) begin errors++; $display("FAIL rr_data%0d: got %h expected %h", f, snap(), e); end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [17:0] e;
        do_reset();
        req_valid = 4'b0100;
        req_data[23:16] = 8'h41;
        @(negedge clk);
        tick();
        @(negedge clk);
        e = pack(4'h0, 1'b1, 8'hA2, 4'h4, 1'b1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL stall_hdr: got %h expected %h", snap(), e); end
        tick();
        @(negedge clk);
        e = pack(4'h4, 1'b1, 8'h41, 4'h4, 1'b1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL stall_first: got %h expected %h", snap(), e); end
        tick();
        req_data[23:16] = 8'h42;
        tx_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            e = pack(4'h0, 1'b0, 8'h42, 4'h4, 1'b1);
            checks++;
            if (snap() !== e) begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", s, snap(), e); end
            tick();
        end
        tx_full = 1'b0;
        @(negedge clk);
        e = pack(4'h4, 1'b1, 8'h42, 4'h4, 1'b1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL stall_release: got %h expected %h", snap(), e); end
        tick();
        req_data[23:16] = 8'h43;
        req_last[2]     = 1'b1;
        @(negedge clk);
        e = pack(4'h4, 1'b1, 8'h43, 4'h4, 1'b1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL stall_last: got %h expected %h", snap(), e); end
        tick();
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        e = pack(4'h0, 1'b0, 8'h00, 4'h0, 1'b0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL stall_done: got %h expected %h", snap(), e); end
        tick();
    endtask

    task automatic test_valid_gap();
        logic [17:0] e;
        do_reset();
        req_valid = 4'b1010;
        req_last  = 4'b1000;
        req_data[15:8]  = 8'h31;
        req_data[31:24] = 8'h77;
        @(negedge clk);
        tick();
        @(negedge clk);
        e = pack(4'h0, 1'b1, 8'hA1, 4'h2, 1'b1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL gap_hdr: got %h expected %h", snap(), e); end
        tick();
        @(negedge clk);
        e = pack(4'h2, 1'b1, 8'h31, 4'h2, 1'b1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL gap_first: got %h expected %h", snap(), e); end
        tick();
        req_valid = 4'b1000;
        req_data[15:8] = 8'h32;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            e = pack(4'h2, 1'b0, 8'h32, 4'h2, 1'b1);
            checks++;
            if (snap() !== e) begin errors++; $display("FAIL gap_hold%0d: got %h expected %h", s, snap(), e); end
            tick();
        end
        req_valid = 4'b1010;
        req_last  = 4'b1010;
        @(negedge clk);
        e = pack(4'h2, 1'b1, 8'h32, 4'h2, 1'b1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL gap_last: got %h expected %h", snap(), e); end
        tick();
        req_valid = 4'b1000;
        req_last  = 4'b1000;
        @(negedge clk);
        e = pack(4'h0, 1'b0, 8'h00, 4'h0, 1'b0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL gap_idle: got %h expected %h", snap(), e); end
        tick();
        @(negedge clk);
        e = pack(4'h0, 1'b1, 8'hA3, 4'h8, 1'b1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL gap_next_owner: got %h expected %h", snap(), e); end
        tick();
    endtask

    task automatic test_no_hdr();
        logic [17:0] e;
        do_reset();
        req_valid = 4'b1000;
        req_last  = 4'b1000;
        req_data[31:24] = 8'h5A;
        @(negedge clk);
        e = pack(4'h0, 1'b0, 8'h00, 4'h0, 1'b0);
        checks++;
        if (snap0() !== e) begin errors++; $display("FAIL nohdr_idle: got %h expected %h", snap0(), e); end
        tick();
        @(negedge clk);
        e = pack(4'h8, 1'b1, 8'h5A, 4'h8, 1'b1);
        checks++;
        if (snap0() !== e) begin errors++; $display("FAIL nohdr_byte: got %h expected %h", snap0(), e); end
        tick();
        req_valid = 4'b1001;
        req_last  = 4'b1001;
        req_data[7:0] = 8'h66;
        @(negedge clk);
        e = pack(4'h0, 1'b0, 8'h00, 4'h0, 1'b0);
        checks++;
        if (snap0() !== e) begin errors++; $display("FAIL nohdr_gap: got %h expected %h", snap0(), e); end
        tick();
        @(negedge clk);
        e = pack(4'h1, 1'b1, 8'h66, 4'h1, 1'b1);
        checks++;
        if (snap0() !== e) begin errors++; $display("FAIL nohdr_next: got %h expected %h", snap0(), e); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [17:0] e;
        do_reset();
        req_valid = 4'b0010;
        req_data[15:8] = 8'h21;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        e = pack(4'h2, 1'b1, 8'h21, 4'h2, 1'b1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL rstmid_data: got %h expected %h", snap(), e); end
        #1;
        rst = 1'b1;
        #1;
        e = pack(4'h0, 1'b0, 8'h00, 4'h0, 1'b0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL rstmid_async: got %h expected %h", snap(), e); end
        checks++;
        if (snap0() !== e) begin errors++; $display("FAIL rstmid_async_nohdr: got %h expected %h", snap0(), e); end
        req_valid = 4'b0011;
        req_data[7:0] = 8'h01;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL rstmid_idle: got %h expected %h", snap(), e); end
        tick();
        @(negedge clk);
        e = pack(4'h0, 1'b1, 8'hA0, 4'h1, 1'b1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL rstmid_winner: got %h expected %h", snap(), e); end
        tick();
    endtask

    task automatic test_random();
        int          owner, last_owner, done_frames, len;
        bit          hdr_pend;
        logic [17:0] e;
        logic [3:0]  exp_rd, exp_gr;
        logic        exp_en;
        logic [7:0]  exp_wd;
        logic [8:0]  b;
        do_reset();
        for (int i = 0; i < N_REQ; i++) rq[i].delete();
        owner = -1; last_owner = N_REQ - 1; hdr_pend = 1'b0; done_frames = 0;
        for (int c = 0; c < 3000; c++) begin
            tx_full = ($urandom_range(9) < 3);
            for (int i = 0; i < N_REQ; i++) begin
                if (rq[i].size() == 0) begin
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++) rq[i].push_back({(j == len - 1), 8'($urandom)});
                end
                req_valid[i] = ($urandom_range(9) < 7);
                if (req_valid[i]) begin
                    req_data[i*N_BIT +: N_BIT] = rq[i][0][7:0];
                    req_last[i] = rq[i][0][8];
                end else begin
                    req_data[i*N_BIT +: N_BIT] = 8'($urandom);
                    req_last[i] = 1'($urandom);
                end
            end
            @(negedge clk);
            exp_rd = '0; exp_en = 1'b0; exp_wd = '0; exp_gr = '0;
            if (owner >= 0) begin
                exp_gr = 4'(1 << owner);
                if (hdr_pend) begin
                    exp_en = !tx_full;
                    exp_wd = 8'(8'hA0 + owner);
                end else begin
                    if (!tx_full) exp_rd = exp_gr;
                    exp_en = req_valid[owner] && !tx_full;
                    exp_wd = exp_en ? rq[owner][0][7:0] : req_data[owner*N_BIT +: N_BIT];
                end
            end
            e = pack(exp_rd, exp_en, exp_wd, exp_gr, (owner >= 0));
            checks++;
            if (snap() !== e) begin errors++; $display("FAIL rand_cycle%0d: got %h expected %h", c, snap(), e); end
            if (owner < 0) begin
                if (req_valid != '0) begin
                    for (int k = 1; k <= N_REQ; k++) begin
                        if (owner < 0 && req_valid[(last_owner + k) % N_REQ]) owner = (last_owner + k) % N_REQ;
                    end
                    hdr_pend = 1'b1;
                end
            end else if (hdr_pend) begin
                if (!tx_full) hdr_pend = 1'b0;
            end else if (exp_en) begin
                b = rq[owner].pop_front();
                if (b[8]) begin
                    last_owner = owner;
                    owner      = -1;
                    done_frames++;
                end
            end
            tick();
        end
        checks++;
        if (done_frames < 50) begin errors++; $display("FAIL rand_progress: got %0d frames expected at least 50", done_frames); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_stall();
        test_valid_gap();
        test_no_hdr();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
